// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, no parity, 1 stop bit.
// Oversamples a synchronised rx line on clk_en ticks and presents each good
// byte on a held output with a ready/clear handshake plus sticky error flags.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       clk_en,
    input  logic       rdy_clr,
    output logic [7:0] data_output,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bitpos_q, bitpos_d;
    logic [7:0]      shift_q, shift_d;
    logic            armed_q, armed_d;
    logic [7:0]      data_q, data_d;
    logic            rdy_q, rdy_d;
    logic            fe_q, fe_d;
    logic            ovr_q, ovr_d;
    logic            busy_q;

    // Two-flop synchroniser on the asynchronous line, idle-high at reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; only advances on oversampling ticks
    always_comb begin
        state_d = state_q;
        if (clk_en) begin
            case (state_q)
                StIdle: begin
                    if (armed_q && !rx_s_q) state_d = StStart;
                end
                StStart: begin
                    // Mid start bit: a high line means the edge was a glitch
                    if (cnt_q == CntHalf) state_d = rx_s_q ? StIdle : StData;
                end
                StData: begin
                    if (cnt_q == CntFull && bitpos_q == 3'd7) state_d = StStop;
                end
                StStop: begin
                    // Leave at mid stop bit so back-to-back starts are caught
                    if (cnt_q == CntFull) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: counters, shift register, arming and handshake flags
    always_comb begin
        cnt_d    = cnt_q;
        bitpos_d = bitpos_q;
        shift_d  = shift_q;
        armed_d  = armed_q;
        data_d   = data_q;
        // Clear first so a set event later in this block wins
        rdy_d    = rdy_clr ? 1'b0 : rdy_q;
        fe_d     = rdy_clr ? 1'b0 : fe_q;
        ovr_d    = rdy_clr ? 1'b0 : ovr_q;
        if (clk_en) begin
            case (state_q)
                StIdle: begin
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        cnt_d = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        if (!rx_s_q) begin
                            cnt_d    = '0;
                            bitpos_d = 3'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == CntFull) begin
                        shift_d[bitpos_q] = rx_s_q;
                        cnt_d             = '0;
                        if (bitpos_q != 3'd7) bitpos_d = bitpos_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == CntFull) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            data_d = shift_q;
                            rdy_d  = 1'b1;
                            if (rdy_q && !rdy_clr) ovr_d = 1'b1;
                        end else begin
                            // Disarm so a stuck-low line cannot look like a start
                            fe_d    = 1'b1;
                            armed_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    // Datapath and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            bitpos_q <= 3'd0;
            shift_q  <= 8'h00;
            armed_q  <= 1'b0;
            data_q   <= 8'h00;
            rdy_q    <= 1'b0;
            fe_q     <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bitpos_q <= bitpos_d;
            shift_q  <= shift_d;
            armed_q  <= armed_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            fe_q     <= fe_d;
            ovr_q    <= ovr_d;
            busy_q   <= (state_q != StIdle);
        end
    end

    assign data_output = data_q;
    assign rdy         = rdy_q;
    assign frame_err   = fe_q;
    assign overrun     = ovr_q;
    assign rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, checked against a
// frame-level model of the byte/flag handshake.
module tb_uart_rx;

    localparam int unsigned Os  = 16;
    localparam int          Div = 3;   // clk cycles per clk_en tick

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic       clk_en  = 1'b0;
    logic       rdy_clr = 1'b0;
    logic [7:0] data_output;
    logic       rdy, frame_err, overrun, rx_busy;

    uart_rx #(.OVERSAMPLE(Os)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .clk_en      (clk_en),
        .rdy_clr     (rdy_clr),
        .data_output (data_output),
        .rdy         (rdy),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    // One-cycle tick every Div clocks, changed away from the active edge
    int div_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            clk_en  = (div_cnt == Div - 1);
            div_cnt = (div_cnt + 1) % Div;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: what the consumer should see after each whole frame
    logic [7:0] exp_data = 8'h00;
    logic       exp_rdy  = 1'b0;
    logic       exp_fe   = 1'b0;
    logic       exp_ovr  = 1'b0;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  at_tick  = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_data"},    data_output,      exp_data);
        check({tag, "_rdy"},     {7'd0, rdy},       {7'd0, exp_rdy});
        check({tag, "_ferr"},    {7'd0, frame_err}, {7'd0, exp_fe});
        check({tag, "_overrun"}, {7'd0, overrun},   {7'd0, exp_ovr});
    endtask

    // Returns 1 time unit after a clk edge on which clk_en was high
    task automatic wait_tick();
        do @(posedge clk); while (clk_en !== 1'b1);
        #1;
        at_tick = 1'b1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_ticks(Os);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        if (!at_tick) wait_tick();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        if (stop) begin
            exp_ovr  = exp_ovr | exp_rdy;
            exp_rdy  = 1'b1;
            exp_data = d;
        end else begin
            exp_fe = 1'b1;
        end
    endtask

    // Raises rdy_clr on exactly the clock of the mid-stop-bit sample tick
    task automatic send_frame_clr_at_stop(input logic [7:0] d);
        if (!at_tick) wait_tick();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        rx = 1'b1;
        wait_ticks(Os / 2);
        repeat (Div - 1) @(posedge clk);
        #1 rdy_clr = 1'b1;
        @(posedge clk);
        #1 rdy_clr = 1'b0;
        wait_ticks(Os / 2 - 1);
        exp_rdy  = 1'b1;
        exp_fe   = 1'b0;
        exp_ovr  = 1'b0;
        exp_data = d;
    endtask

    task automatic idle_ticks(input int n);
        rx = 1'b1;
        wait_ticks(n);
    endtask

    task automatic clear_flags();
        rdy_clr = 1'b1;
        @(posedge clk);
        #1 rdy_clr = 1'b0;
        at_tick = 1'b0;
        exp_rdy = 1'b0;
        exp_fe  = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        logic [7:0] rnd_byte;
        logic       rnd_stop;

        // Reset
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        check_all("reset");
        check("reset_busy", {7'd0, rx_busy}, 8'd0);
        idle_ticks(2 * Os);

        // Clean frame
        send_frame(8'h55, 1'b1);
        check_all("clean");
        check("clean_busy", {7'd0, rx_busy}, 8'd0);
        clear_flags();
        check_all("clean_clr");

        // Start glitch, then a real frame
        wait_tick();
        rx = 1'b0;
        wait_ticks(4);
        check("glitch_busy_hi", {7'd0, rx_busy}, 8'd1);
        idle_ticks(Os);
        check("glitch_busy_lo", {7'd0, rx_busy}, 8'd0);
        check_all("glitch");
        send_frame(8'hA7, 1'b1);
        check_all("after_glitch");
        clear_flags();

        // Framing error followed by a stuck-low line
        send_frame(8'hA3, 1'b0);
        rx = 1'b0;
        wait_ticks(20 * Os);
        check_all("ferr");
        check("ferr_busy", {7'd0, rx_busy}, 8'd0);
        idle_ticks(2 * Os);
        check_all("ferr_idle");
        send_frame(8'h3C, 1'b1);
        check_all("ferr_recover");
        clear_flags();

        // Overrun with back-to-back frames
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        check_all("overrun");
        clear_flags();
        check_all("overrun_clr");

        // Clear coinciding with the stop sample while rdy is already set
        idle_ticks(Os);
        send_frame(8'h5A, 1'b1);
        send_frame_clr_at_stop(8'h81);
        check_all("simul");

        // Reset in the middle of a frame
        clear_flags();
        wait_tick();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        at_tick  = 1'b0;
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        exp_fe   = 1'b0;
        exp_ovr  = 1'b0;
        check_all("midreset");
        check("midreset_busy", {7'd0, rx_busy}, 8'd0);
        idle_ticks(5 * Os);
        check_all("midreset_tail");
        send_frame(8'hC9, 1'b1);
        check_all("midreset_next");

        // Random frames with occasional bad stop bits, gaps and clears
        for (int n = 0; n < 24; n++) begin
            rnd_byte = 8'($urandom);
            rnd_stop = ($urandom_range(0, 4) != 0);
            send_frame(rnd_byte, rnd_stop);
            check_all($sformatf("rand%0d", n));
            if (!rnd_stop) begin
                idle_ticks(2 * Os);
            end else begin
                idle_ticks($urandom_range(0, 20));
            end
            if ($urandom_range(0, 1) == 1) begin
                clear_flags();
                check_all($sformatf("rand%0d_clr", n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the team's `uart_tx`: 8 data bits, LSB first, no parity, 1 stop bit.
- Samples the asynchronous `rx` line using a single-cycle oversampling enable (`clk_en`, OVERSAMPLE × baud) from the shared baud generator.
- Validates start and stop bits and presents each received byte on a held output with a ready/clear handshake.
- Sits between the board serial pin and the command-parsing logic that consumes bytes.

## Interface
- OVERSAMPLE, 16: `clk_en` ticks per bit period; even, ≥4; counters sized `$clog2(OVERSAMPLE)`.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- clk_en  input  1  one-`clk`-wide oversampling tick.
- rdy_clr  input  1  consumer acknowledge; clears `rdy`, `frame_err`, `overrun`.
- data_output  output  8  last good byte; held until the next good byte.
- rdy  output  1  byte available.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun  output  1  sticky: good byte completed while `rdy` was already 1.
- rx_busy  output  1  registered; 1 when the state was not IDLE on the previous cycle.

## Operation
- Synchronizer: two flops on `rx` give `rx_s`. Both flops reset to 1.
- Registers: `cnt` (tick counter), `bitpos` (3 bits), `shift` (8 bits), `armed` (1 bit).
- FSM states are IDLE, START, DATA and STOP. All FSM activity occurs only on cycles where `clk_en` = 1.
- IDLE:
  - If `rx_s` = 1, set `armed` = 1.
  - If `armed` and `rx_s` = 0, go to START with `cnt` = 0.
- START:
  - If `cnt` = OVERSAMPLE/2−1: when `rx_s` = 0, go to DATA with `cnt` = 0 and `bitpos` = 0; otherwise it is a glitch, go to IDLE.
  - Else `cnt` ← `cnt`+1.
- DATA:
  - If `cnt` = OVERSAMPLE−1: `shift[bitpos]` ← `rx_s` and `cnt` ← 0. If `bitpos` = 7, go to STOP; else `bitpos` ← `bitpos`+1.
  - Else `cnt` ← `cnt`+1.
- STOP:
  - If `cnt` = OVERSAMPLE−1, go to IDLE in all cases.
  - When `rx_s` = 1 (good frame): `data_output` ← `shift`, `rdy` ← 1, `overrun` ← `rdy` & ~`rdy_clr`.
  - When `rx_s` = 0 (bad frame): `frame_err` ← 1, `armed` ← 0. `data_output` and `rdy` are unchanged.
  - Else `cnt` ← `cnt`+1.
- Flag priority:
  - `rdy_clr` clears `rdy`, `frame_err` and `overrun` on any cycle.
  - A set event in the same cycle wins over `rdy_clr`.
- Break or stuck-low line: after a frame error, no new start is recognised until `rx_s` has been sampled high on a tick in IDLE.
- Illegal state encoding → IDLE.

## Timing
- Reset values:
  - Outputs: `data_output` = 0x00, `rdy` = 0, `frame_err` = 0, `overrun` = 0, `rx_busy` = 0.
  - Internal: state = IDLE, `cnt` = 0, `bitpos` = 0, `shift` = 0x00, `armed` = 0, synchronizer = 1.
- Reset mid-frame aborts the frame immediately; `armed` = 0 guarantees resynchronisation on the next idle-high period.
- Input latency: 2 `clk` through the synchronizer.
- Start sample: OVERSAMPLE/2 ticks after the falling-edge detect tick (mid start bit).
- Data samples: every OVERSAMPLE ticks thereafter (mid-bit).
- `rdy` rises on the `clk` edge of the stop-bit sample tick, 9.5 bit periods after the start detect (±1 tick).
- Back-to-back frames are supported: IDLE is re-entered at mid stop bit, leaving half a bit for start detection.
- `rx_busy` lags the state by one `clk`.

## Test plan
- Clean frame, loopback: `uart_tx` sends 0x55 (tx `clk_en` every 16th rx tick). Required: `data_output` = 0x55, `rdy` = 1, `frame_err` = 0, `overrun` = 0. After `rdy_clr`: `rdy` = 0, `data_output` still 0x55.
- Start glitch: `rx` low for 4 ticks, then high. Required: return to IDLE before DATA, no `rdy`, `rx_busy` back to 0; a following 0xA7 frame is received correctly.
- Framing error: 0xA3 sent with stop bit = 0, then line held low for 20 bit times. Required: `frame_err` = 1, `rdy` = 0, `data_output` unchanged, no further frame detected. After line goes high and 0x3C is sent: `rdy` = 1 with 0x3C.
- Overrun: 0x12 then 0x34 back-to-back with no `rdy_clr`. Required: `data_output` = 0x34, `rdy` = 1, `overrun` = 1. A single `rdy_clr` clears all three flags.
- Simultaneous set/clear: `rdy_clr` asserted on the exact cycle of the 0x81 stop sample. Required: `rdy` = 1 afterwards and `overrun` = 0.
- Reset mid-frame: `rst` pulsed after bit 3 of 0xF0, line stays in frame. Required: all outputs = reset values, no spurious byte. Next 0xC9 frame: `rdy` = 1 with `data_output` = 0xC9.
